// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush controller with load-use, flag, BR-register and memory-busy handling.
// Optional STALL_STATS_EN adds saturating stall/bubble/flush counters.
module hazard_stall_ctrl #(
    parameter int REG_W  = 4,
    parameter int FLAG_W = 3
`ifdef STALL_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_branch,
    input  logic              id_br_reg,
    input  logic              branch_taken,
    input  logic              ex_memread,
    input  logic              ex_regwrite,
    input  logic [REG_W-1:0]  ex_dst,
    input  logic [FLAG_W-1:0] ex_fwr,
    input  logic              imem_busy,
    input  logic              dmem_busy,
    input  logic              halt_wb,
    output logic              pc_wren,
    output logic              ifid_wren,
    output logic              ifid_flush,
    output logic              idex_wren,
    output logic              idex_flush,
    output logic              exmem_wren,
    output logic              memwb_wren,
    output logic              halted,
    output logic [1:0]        ctrl_state
`ifdef STALL_STATS_EN
    , output logic [CNT_W-1:0] stall_cycles
    , output logic [CNT_W-1:0] bubble_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, IWAIT = 2'd2, HALT = 2'd3} state_t;

    state_t state, state_nx;
    logic   halted_q;
    logic   dst_ok, lu, fh, bh, hz;

    // r0 is hardwired zero, so a producer targeting it never creates a dependency
    assign dst_ok = ex_dst != '0;
    assign lu = ex_memread & dst_ok & ((id_uses_rs & (id_rs == ex_dst)) | (id_uses_rt & (id_rt == ex_dst)));
    assign fh = id_branch & (ex_fwr != '0);
    assign bh = id_br_reg & ex_regwrite & dst_ok & (id_rs == ex_dst);
    assign hz = lu | fh | bh;

    always_comb begin
        state_nx   = RUN;
        pc_wren    = 1'b1;
        ifid_wren  = 1'b1;
        ifid_flush = 1'b0;
        idex_wren  = 1'b1;
        idex_flush = 1'b0;
        exmem_wren = 1'b1;
        memwb_wren = 1'b1;
        if (state == HALT || halt_wb) begin
            state_nx   = HALT;
            pc_wren    = 1'b0;
            ifid_wren  = 1'b0;
            idex_wren  = 1'b0;
            exmem_wren = 1'b0;
            memwb_wren = 1'b0;
        end else if (dmem_busy) begin
            state_nx   = DWAIT;
            pc_wren    = 1'b0;
            ifid_wren  = 1'b0;
            idex_wren  = 1'b0;
            exmem_wren = 1'b0;
            memwb_wren = 1'b0;
        end else if (imem_busy || hz) begin
            state_nx   = imem_busy ? IWAIT : RUN;
            pc_wren    = 1'b0;
            ifid_wren  = 1'b0;
            idex_flush = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nx;
            halted_q <= state_nx == HALT;
        end
    end

    assign halted     = halted_q | halt_wb;
    assign ctrl_state = state;

`ifdef STALL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            bubble_cnt   <= '0;
            flush_cnt    <= '0;
        end else if (state != HALT) begin
            if (!pc_wren && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (idex_flush && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
            if (ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: table-driven directed checks plus multi-cycle stall, freeze and halt sequences.
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] id_rs, id_rt, ex_dst;
    logic [2:0] ex_fwr;
    logic id_uses_rs, id_uses_rt, id_branch, id_br_reg, branch_taken;
    logic ex_memread, ex_regwrite, imem_busy, dmem_busy, halt_wb;
    logic pc_wren, ifid_wren, ifid_flush, idex_wren, idex_flush, exmem_wren, memwb_wren, halted;
    logic [1:0] ctrl_state;
`ifdef STALL_STATS_EN
    logic [15:0] stall_cycles, bubble_cnt, flush_cnt;
`endif
    int total = 0;
    int bad = 0;

    // {pc, ifid, ifid_flush, idex, idex_flush, exmem, memwb}
    localparam logic [6:0] RUN_ALL = 7'b1101011;
    localparam logic [6:0] BUB     = 7'b0001111;
    localparam logic [6:0] BRF     = 7'b1111011;
    localparam logic [6:0] FRZ     = 7'b0000000;

    hazard_stall_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_branch(id_branch), .id_br_reg(id_br_reg),
        .branch_taken(branch_taken), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_dst(ex_dst), .ex_fwr(ex_fwr), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .halt_wb(halt_wb), .pc_wren(pc_wren), .ifid_wren(ifid_wren), .ifid_flush(ifid_flush),
        .idex_wren(idex_wren), .idex_flush(idex_flush), .exmem_wren(exmem_wren),
        .memwb_wren(memwb_wren), .halted(halted), .ctrl_state(ctrl_state)
`ifdef STALL_STATS_EN
        , .stall_cycles(stall_cycles), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rs, rt, dst;
        logic [2:0] fwr;
        logic       urs, urt, br, brr, tk, mr, rw, ib, db;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic [3:0] rs, input logic [3:0] rt, input logic urs, input logic urt,
                                input logic br, input logic brr, input logic tk, input logic mr, input logic rw,
                                input logic [3:0] dst, input logic [2:0] fwr, input logic ib, input logic db,
                                input logic [6:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br; v.brr = brr; v.tk = tk;
        v.mr = mr; v.rw = rw; v.dst = dst; v.fwr = fwr; v.ib = ib; v.db = db; v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {pc_wren, ifid_wren, ifid_flush, idex_wren, idex_flush, exmem_wren, memwb_wren};
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt; id_branch = v.br;
        id_br_reg = v.brr; branch_taken = v.tk; ex_memread = v.mr; ex_regwrite = v.rw;
        ex_dst = v.dst; ex_fwr = v.fwr; imem_busy = v.ib; dmem_busy = v.db;
    endtask

    task automatic clear();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_ALL));
        halt_wb = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        next_cycle();
        rst = 1'b1;
    endtask

    initial begin
        clear();
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, RUN_ALL);
        vecs[1]  = mk(0, 4, 0, 1, 0, 0, 0, 1, 1, 4, 3'b000, 0, 0, BUB);
        vecs[2]  = mk(5, 0, 1, 0, 0, 0, 0, 1, 1, 5, 3'b000, 0, 0, BUB);
        vecs[3]  = mk(0, 4, 0, 0, 0, 0, 0, 1, 1, 4, 3'b000, 0, 0, RUN_ALL);
        vecs[4]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 3'b000, 0, 0, RUN_ALL);
        vecs[5]  = mk(3, 2, 1, 1, 0, 0, 0, 1, 1, 4, 3'b000, 0, 0, RUN_ALL);
        vecs[6]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 3'b001, 0, 0, BUB);
        vecs[7]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 0, 0, BRF);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, RUN_ALL);
        vecs[9]  = mk(7, 0, 1, 0, 0, 1, 0, 0, 1, 7, 3'b000, 0, 0, BUB);
        vecs[10] = mk(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 3'b000, 0, 0, RUN_ALL);
        vecs[11] = mk(7, 0, 1, 0, 0, 1, 0, 0, 0, 7, 3'b000, 0, 0, RUN_ALL);
        vecs[12] = mk(6, 0, 1, 0, 0, 0, 0, 0, 1, 6, 3'b000, 0, 0, RUN_ALL);
        vecs[13] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 1, 0, BUB);
        vecs[14] = mk(0, 4, 0, 1, 0, 0, 0, 1, 1, 4, 3'b000, 0, 1, FRZ);

        #2;
        check("reset_outs", outs(), RUN_ALL);
        check("reset_state", {5'b0, ctrl_state}, 7'd0);
        check("reset_halted", {6'b0, halted}, 7'd0);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
            check($sformatf("vec%0d_halted", i), {6'b0, halted}, 7'd0);
            next_cycle();
        end

        clear();
        do_reset();
        apply(vecs[1]);
        @(negedge clk);
        check("lu_bubble", outs(), BUB);
        next_cycle();
        ex_memread = 1'b0;
        @(negedge clk);
        check("lu_release", outs(), RUN_ALL);
        next_cycle();

        apply(vecs[1]);
        dmem_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("dmem_frz%0d", c), outs(), FRZ);
            if (c > 0) check($sformatf("dmem_state%0d", c), {5'b0, ctrl_state}, 7'd1);
            next_cycle();
        end
        dmem_busy = 1'b0;
        @(negedge clk);
        check("dmem_rel_bubble", outs(), BUB);
        check("dmem_rel_state", {5'b0, ctrl_state}, 7'd1);
        next_cycle();
        ex_memread = 1'b0;
        @(negedge clk);
        check("dmem_after", outs(), RUN_ALL);
        check("dmem_after_state", {5'b0, ctrl_state}, 7'd0);
        next_cycle();

        clear();
        imem_busy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("imem_bub%0d", c), outs(), BUB);
            if (c > 0) check("imem_state", {5'b0, ctrl_state}, 7'd2);
            next_cycle();
        end
        imem_busy = 1'b0;
        @(negedge clk);
        check("imem_rel", outs(), RUN_ALL);
        next_cycle();
        @(negedge clk);
        check("imem_after_state", {5'b0, ctrl_state}, 7'd0);
        next_cycle();

        halt_wb = 1'b1;
        @(negedge clk);
        check("halt_outs", outs(), FRZ);
        check("halt_flag", {6'b0, halted}, 7'd1);
        next_cycle();
        halt_wb = 1'b0;
        apply(vecs[7]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("halt_hold%0d", c), outs(), FRZ);
            check($sformatf("halt_flag%0d", c), {6'b0, halted}, 7'd1);
            check($sformatf("halt_state%0d", c), {5'b0, ctrl_state}, 7'd3);
            next_cycle();
        end
        clear();
        #2;
        rst = 1'b0;
        #1;
        check("areset_halted", {6'b0, halted}, 7'd0);
        check("areset_state", {5'b0, ctrl_state}, 7'd0);
        check("areset_outs", outs(), RUN_ALL);
        next_cycle();
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
